mem_access_stage: RTL and testbench

- Memory-access pipeline stage. Consumes the execute stage's M-side outputs and drives a data-memory request/acknowledge bus.
- Stalls the pipeline while an access is outstanding.
- Registers results into the M/W boundary and produces ResultW, which feeds back to the execute-stage forwarding muxes.
- Sits between the execute stage and register-file writeback.

---
 rtl/mem_access_stage_if.sv | 30 +++
 rtl/mem_access_stage.sv | 129 ++++++++++++
 tb/tb_mem_access_stage.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge bus between the memory-access stage (master)
// and the data memory (slave).
interface mem_access_stage_if #(
    parameter int DATA_W = 32
);
    logic              dmem_req;
    logic              dmem_we;
    logic [DATA_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic [DATA_W-1:0] dmem_rdata;
    logic              dmem_ack;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_rdata,
        input  dmem_ack
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_rdata,
        output dmem_ack
    );
endinterface

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: drives the data-memory bus, stalls while an access
// is outstanding and registers the M/W boundary. Optional abort-on-timeout: MEM_TIMEOUT_EN.
module mem_access_stage #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWriteM,
    input  logic              MemWriteM,
    input  logic              ResultSrcM,
    input  logic [5:0]        RD_M,
    input  logic [DATA_W-1:0] PCPlus4M,
    input  logic [DATA_W-1:0] WriteDataM,
    input  logic [DATA_W-1:0] ALU_ResultM,
    mem_access_stage_if.master dmem,
    output logic              StallM,
    output logic              RegWriteW,
    output logic              ResultSrcW,
    output logic [5:0]        RD_W,
    output logic [DATA_W-1:0] ALU_ResultW,
    output logic [DATA_W-1:0] ReadDataW,
    output logic [DATA_W-1:0] PCPlus4W,
    output logic [DATA_W-1:0] ResultW,
    output logic              misalign_err,
    output logic              timeout_err
);
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t state_r;
    logic   memop_s;
    logic   misaligned_s;
    logic   misalign_drop_s;
    logic   want_req_s;
    logic   timeout_s;
    logic   req_s;
    logic   done_s;
    logic   bubble_s;

    assign memop_s         = MemWriteM | ResultSrcM;
    assign misaligned_s    = memop_s & (ALU_ResultM[1:0] != 2'b00);
    assign misalign_drop_s = (state_r == IDLE) & misaligned_s;
    assign want_req_s      = (state_r == WAIT) | (memop_s & ~misaligned_s);

    // Gating with rst makes the request vanish the instant reset is asserted.
    assign req_s    = rst & want_req_s & ~timeout_s;
    assign done_s   = req_s & dmem.dmem_ack;
    assign StallM   = req_s & ~dmem.dmem_ack;
    assign bubble_s = misalign_drop_s | StallM | timeout_s;

    assign dmem.dmem_req   = req_s;
    assign dmem.dmem_we    = MemWriteM;
    assign dmem.dmem_addr  = ALU_ResultM;
    assign dmem.dmem_wdata = WriteDataM;

    assign ResultW = ResultSrcW ? ReadDataW : ALU_ResultW;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_r;

    // Wait counter: primed to 1 from IDLE, counts WAIT cycles and saturates at TIMEOUT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= '0;
        end else if (state_r == IDLE) begin
            cnt_r <= CNT_W'(1);
        end else if (cnt_r != CNT_W'(TIMEOUT)) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // A same-cycle ack takes priority over the abort.
    assign timeout_s = (state_r == WAIT) & (cnt_r == CNT_W'(TIMEOUT)) & ~dmem.dmem_ack;
`else
    assign timeout_s = 1'b0;
`endif

    // Access FSM, M/W boundary registers and error pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            RegWriteW    <= 1'b0;
            ResultSrcW   <= 1'b0;
            RD_W         <= 6'h00;
            ALU_ResultW  <= '0;
            ReadDataW    <= '0;
            PCPlus4W     <= '0;
            misalign_err <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_s && !dmem.dmem_ack) begin
                        state_r <= WAIT;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                WAIT: begin
                    if (done_s || timeout_s) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                default: state_r <= IDLE;
            endcase

            RegWriteW   <= RegWriteM & ~bubble_s;
            ResultSrcW  <= ResultSrcM;
            RD_W        <= RD_M;
            ALU_ResultW <= ALU_ResultM;
            PCPlus4W    <= PCPlus4M;
            if (done_s && ResultSrcM && !MemWriteM) begin
                ReadDataW <= dmem.dmem_rdata;
            end else begin
                ReadDataW <= ReadDataW;
            end
            misalign_err <= misalign_drop_s;
            timeout_err  <= timeout_s;
        end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage: a driver issues instructions and plays the
// memory, a monitor pops expected W-stage results from a scoreboard queue.
module tb_mem_access_stage;
    localparam int DW = 32;
    localparam int TO = 4;
`ifdef MEM_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          RegWriteM = 1'b0, MemWriteM = 1'b0, ResultSrcM = 1'b0;
    logic [5:0]    RD_M = 6'h00;
    logic [DW-1:0] PCPlus4M = '0, WriteDataM = '0, ALU_ResultM = '0;
    logic          StallM, RegWriteW, ResultSrcW, misalign_err, timeout_err;
    logic [5:0]    RD_W;
    logic [DW-1:0] ALU_ResultW, ReadDataW, PCPlus4W, ResultW;

    mem_access_stage_if #(.DATA_W(DW)) dbus ();

    mem_access_stage #(.DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM),
        .dmem(dbus.master),
        .StallM(StallM), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RD_W(RD_W),
        .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W),
        .ResultW(ResultW), .misalign_err(misalign_err), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          regw;
        logic          rsrc;
        logic [5:0]    rd;
        logic [DW-1:0] alu;
        logic [DW-1:0] pc4;
        logic [DW-1:0] rdata;
        logic          mis;
        logic          tmo;
    } exp_t;

    exp_t          sb_q[$];
    int            tests = 0;
    int            fails = 0;
    logic [DW-1:0] last_rd = '0;
    logic          retire_r = 1'b0;
    logic          stall_r = 1'b0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every cycle in which the stage let an instruction go, compare W against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (retire_r) begin
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", 96'd1, 96'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("RegWriteW", RegWriteW, e.regw);
                    chk("ResultSrcW", ResultSrcW, e.rsrc);
                    chk("RD_W", RD_W, e.rd);
                    chk("ALU_ResultW", ALU_ResultW, e.alu);
                    chk("PCPlus4W", PCPlus4W, e.pc4);
                    chk("ReadDataW", ReadDataW, e.rdata);
                    chk("ResultW", ResultW, e.rsrc ? e.rdata : e.alu);
                    chk("misalign_err", misalign_err, e.mis);
                    chk("timeout_err", timeout_err, e.tmo);
                end
            end else if (stall_r) begin
                chk("bubble_RegWriteW", RegWriteW, 1'b0);
                chk("bubble_errs", {misalign_err, timeout_err}, 2'b00);
            end
        end
        #4;
        retire_r = rst && !StallM;
        stall_r  = rst && StallM;
    end

    // Issue one instruction, act as memory with ack after lat cycles, hold until the stage releases it.
    task automatic issue(input logic regw, input logic memw, input logic rsrc, input logic [5:0] rd,
                         input logic [DW-1:0] pc4, input logic [DW-1:0] wd, input logic [DW-1:0] alu,
                         input int lat, input logic [DW-1:0] rdv);
        exp_t e;
        logic mis, mem, tmo, s, exp_req;
        int   exp_stall;
        mis = (memw | rsrc) && (alu[1:0] != 2'b00);
        mem = (memw | rsrc) && !mis;
        tmo = mem && TO_EN && (lat > TO);
        exp_stall = !mem ? 0 : (tmo ? TO : lat);
        if (mem && !tmo && rsrc && !memw) last_rd = rdv;
        e.regw = regw && !mis && !tmo;
        e.rsrc = rsrc; e.rd = rd; e.alu = alu; e.pc4 = pc4;
        e.rdata = last_rd; e.mis = mis; e.tmo = tmo;
        sb_q.push_back(e);
        RegWriteM = regw; MemWriteM = memw; ResultSrcM = rsrc;
        RD_M = rd; PCPlus4M = pc4; WriteDataM = wd; ALU_ResultM = alu;
        for (int k = 0; ; k++) begin
            if (mem) begin
                dbus.dmem_ack   = (k == lat);
                dbus.dmem_rdata = (k == lat) ? rdv : $urandom;
            end else begin
                dbus.dmem_ack   = 1'($urandom_range(0, 1));
                dbus.dmem_rdata = $urandom;
            end
            #4;
            s = StallM;
            exp_req = mem && !(tmo && k == TO);
            chk("dmem_req", dbus.dmem_req, exp_req);
            if (exp_req) chk("bus_we_addr_wdata", {dbus.dmem_we, dbus.dmem_addr, dbus.dmem_wdata},
                             {memw, alu, wd});
            chk("StallM", s, k < exp_stall);
            @(negedge clk);
            if (!s) break;
            if (k >= 64) begin
                chk("stall_bound", 96'd1, 96'd0);
                break;
            end
        end
        dbus.dmem_ack = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_stall"}, {dbus.dmem_req, StallM}, 2'b00);
        chk({tag, "_ctl"}, {RegWriteW, ResultSrcW, RD_W, misalign_err, timeout_err}, 10'h000);
        chk({tag, "_data"}, {ALU_ResultW, ReadDataW, PCPlus4W}, 96'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] a, r;
        int kind;
        dbus.dmem_ack = 1'b0;
        dbus.dmem_rdata = '0;
        // Aligned load on the inputs while in reset: request must stay low.
        ResultSrcM = 1'b1; ALU_ResultM = 32'h0000_0040;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b1;
        issue(1'b1, 1'b0, 1'b0, 6'd5, 32'h0000_0004, 32'h0, 32'h0000_1234, 0, 32'h0);
        issue(1'b1, 1'b0, 1'b1, 6'd7, 32'h0000_0008, 32'h0, 32'h0000_0100, 0, 32'hDEAD_BEEF);
        issue(1'b0, 1'b1, 1'b0, 6'd0, 32'h0000_000C, 32'hA5A5_A5A5, 32'h0000_0200, 3, 32'h0);
        issue(1'b1, 1'b0, 1'b1, 6'd9, 32'h0000_0010, 32'h0, 32'h0000_0102, 0, 32'h1111_1111);
        issue(1'b1, 1'b0, 1'b1, 6'd3, 32'h0000_0014, 32'h0, 32'h0000_0300, 6, 32'h2222_2222);
        issue(1'b1, 1'b0, 1'b1, 6'd4, 32'h0000_0018, 32'h0, 32'h0000_0304, TO, 32'h3333_3333);
        for (int i = 0; i < 300; i++) begin
            kind = $urandom_range(0, 2);
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            r = $urandom;
            issue(1'($urandom_range(0, 1)), kind == 2, kind == 1, 6'($urandom),
                  $urandom, $urandom, a, $urandom_range(0, 7), r);
        end
        // Reset while an access is outstanding.
        RegWriteM = 1'b1; MemWriteM = 1'b0; ResultSrcM = 1'b1; RD_M = 6'd12;
        ALU_ResultM = 32'h0000_0400; dbus.dmem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("midwait");
        last_rd = '0;
        @(negedge clk);
        rst = 1'b1;
        issue(1'b1, 1'b0, 1'b0, 6'd13, 32'h0000_0020, 32'h0, 32'h0000_5678, 0, 32'h0);
        issue(1'b1, 1'b0, 1'b1, 6'd14, 32'h0000_0024, 32'h0, 32'h0000_0500, 2, 32'hCAFE_F00D);
        @(negedge clk);
        @(negedge clk);
        chk("sb_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
